// File: rtl/instr_fetch_seq.sv
// Multicycle instruction-fetch sequencer: owns the PC, reads imem, hands words to decode.
// Optional INSTR_FETCH_PERF_EN adds a saturating fetch_count of completed transfers.
module instr_fetch_seq #(
  parameter int unsigned PC_W    = 6,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic [PC_W-1:0]    pc
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    instr_pc_d;
  logic [INSTR_W-1:0] instr_d;

  // Next-state and datapath update; a redirect overrides everything, including halt.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    instr_d    = instr;
    instr_pc_d = instr_pc;
    if (redirect_valid) begin
      state_d = S_FETCH;
      pc_d    = redirect_pc;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_FETCH;
        S_FETCH:  state_d = S_WAIT;
        S_WAIT: begin
          instr_d    = imem_rdata;
          instr_pc_d = pc;
          pc_d       = pc + PC_W'(1);
          state_d    = S_HOLD;
        end
        S_HOLD: begin
          if (instr_ready) state_d = halt ? S_HALTED : S_FETCH;
        end
        S_HALTED: state_d = S_HALTED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= (state_d == S_HOLD);
    end
  end

  assign imem_addr  = pc;
  assign imem_rd_en = (state_q == S_FETCH);

`ifdef INSTR_FETCH_PERF_EN
  // A HOLD-cycle handshake completes even when a redirect lands in the same cycle.
  logic xfer;
  assign xfer = (state_q == S_HOLD) && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (xfer && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed scenarios plus randomized run vs a behavioural model.
module tb_instr_fetch_seq;
  localparam int unsigned PC_W    = 6;
  localparam int unsigned INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rd_en;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               halt = 1'b0;
  logic [PC_W-1:0]    pc;
`ifdef INSTR_FETCH_PERF_EN
  logic [15:0]        fetch_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [INSTR_W-1:0] mem [64];

  // Behavioural model: age counts cycles since a fetch began (0 = read cycle, 1 = capture).
  logic [PC_W-1:0]    m_pc;
  logic [PC_W-1:0]    m_ipc;
  logic [INSTR_W-1:0] m_instr;
  logic               m_valid;
  logic               m_halted;
  int                 m_age;
  int                 m_count;

  instr_fetch_seq #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .pc             (pc)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic model_reset();
    m_pc = '0; m_ipc = '0; m_instr = '0;
    m_valid = 1'b0; m_halted = 1'b0; m_age = -1; m_count = 0;
  endtask

  task automatic model_step();
    if (redirect_valid) begin
      if (m_valid && instr_ready && m_count < 65535) m_count++;
      m_valid = 1'b0; m_halted = 1'b0; m_pc = redirect_pc; m_age = 0;
    end else if (m_valid) begin
      if (instr_ready) begin
        if (m_count < 65535) m_count++;
        m_valid = 1'b0;
        if (halt) begin m_halted = 1'b1; m_age = -9; end
        else m_age = 0;
      end
    end else if (m_halted) begin
      m_age = -9;
    end else if (m_age == 1) begin
      m_instr = mem[m_pc]; m_ipc = m_pc; m_pc = m_pc + 6'd1;
      m_valid = 1'b1; m_age = -9;
    end else begin
      m_age++;
    end
  endtask

  function automatic logic exp_rd();
    return !m_valid && !m_halted && (m_age == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 64; k++) mem[k] = 16'hA000 + 16'(k);
    #1 rst_n = 1'b0;
    #12;
    n_checks++;
    if ({pc, instr, instr_pc, instr_valid, imem_rd_en, imem_addr} !== '0)
      $display("FAIL reset_outputs pc=%0h instr=%0h ipc=%0h v=%0b rd=%0b addr=%0h expected all 0",
               pc, instr, instr_pc, instr_valid, imem_rd_en, imem_addr);
    else n_pass++;
`ifdef INSTR_FETCH_PERF_EN
    n_checks++;
    if (fetch_count !== 16'd0) $display("FAIL reset_count got %0d expected 0", fetch_count);
    else n_pass++;
`endif
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 6'd0)
      $display("FAIL first_fetch rd=%0b addr=%0d expected rd=1 addr=0", imem_rd_en, imem_addr);
    else n_pass++;
  endtask

  task automatic test_sequential();
    instr_ready = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      n_checks++;
      if (instr_valid !== (t % 3 == 2))
        $display("FAIL seq_valid t=%0d got %0b expected %0b", t, instr_valid, (t % 3 == 2));
      else n_pass++;
      if (t % 3 == 2) begin
        n_checks++;
        if (instr !== 16'hA000 + 16'(t / 3) || instr_pc !== 6'(t / 3))
          $display("FAIL seq_word t=%0d got (%0h,%0d) expected (%0h,%0d)",
                   t, instr, instr_pc, 16'hA000 + 16'(t / 3), t / 3);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 6'd63;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 6'd63 || instr !== 16'hA03F || pc !== 6'd0)
      $display("FAIL wrap_63 v=%0b ipc=%0d instr=%0h pc=%0d expected v=1 ipc=63 instr=a03f pc=0",
               instr_valid, instr_pc, instr, pc);
    else n_pass++;
    tick();
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 6'd0 || instr !== 16'hA000)
      $display("FAIL wrap_0 v=%0b ipc=%0d instr=%0h expected v=1 ipc=0 instr=a000",
               instr_valid, instr_pc, instr);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [INSTR_W-1:0] hold_instr;
    logic [PC_W-1:0]    hold_pc;
    instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 6'd4;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 6'd4 || instr !== 16'hA004)
      $display("FAIL stall_word v=%0b ipc=%0d instr=%0h expected v=1 ipc=4 instr=a004",
               instr_valid, instr_pc, instr);
    else n_pass++;
    hold_instr = instr; hold_pc = instr_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== hold_instr || instr_pc !== hold_pc || imem_rd_en !== 1'b0)
        $display("FAIL stall_hold i=%0d v=%0b instr=%0h ipc=%0d rd=%0b expected v=1 instr=%0h ipc=%0d rd=0",
                 i, instr_valid, instr, instr_pc, imem_rd_en, hold_instr, hold_pc);
      else n_pass++;
    end
    instr_ready = 1'b1;
    tick();
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 6'd5)
      $display("FAIL stall_next rd=%0b addr=%0d expected rd=1 addr=5", imem_rd_en, imem_addr);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    bit seen = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 6'd16;
    tick();
    redirect_valid = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 6'b000100;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 6'd4 || instr_valid !== 1'b0)
      $display("FAIL redir_fetch rd=%0b addr=%0d v=%0b expected rd=1 addr=4 v=0",
               imem_rd_en, imem_addr, instr_valid);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (instr_valid && !seen) begin
        seen = 1'b1;
        n_checks++;
        if (instr_pc !== 6'd4 || instr !== 16'hA004)
          $display("FAIL redir_word got (%0h,%0d) expected (a004,4)", instr, instr_pc);
        else n_pass++;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL redir_timeout got no instr_valid expected one within 8 cycles");
    else n_pass++;
  endtask

  task automatic test_halt();
    instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 6'd7;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 6'd7)
      $display("FAIL halt_word v=%0b ipc=%0d expected v=1 ipc=7", instr_valid, instr_pc);
    else n_pass++;
    halt = 1'b1; instr_ready = 1'b1;
    tick();
    halt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (imem_rd_en !== 1'b0 || instr_valid !== 1'b0)
        $display("FAIL halt_idle i=%0d rd=%0b v=%0b expected rd=0 v=0", i, imem_rd_en, instr_valid);
      else n_pass++;
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 6'h20;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 6'h20)
      $display("FAIL halt_resume rd=%0b addr=%0h expected rd=1 addr=20", imem_rd_en, imem_addr);
    else n_pass++;
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 6'h20)
      $display("FAIL halt_resume_word v=%0b ipc=%0h expected v=1 ipc=20", instr_valid, instr_pc);
    else n_pass++;
  endtask

  task automatic test_random();
    @(negedge clk) rst_n = 1'b0;
    for (int k = 0; k < 64; k++) mem[k] = 16'($urandom);
    tick();
    @(negedge clk) rst_n = 1'b1;
    for (int t = 0; t < 400; t++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = 6'($urandom);
      halt           = ($urandom_range(0, 9) == 0);
      tick();
      n_checks++;
      if (pc !== m_pc || imem_addr !== m_pc)
        $display("FAIL rnd_pc t=%0d pc=%0h addr=%0h expected %0h", t, pc, imem_addr, m_pc);
      else n_pass++;
      n_checks++;
      if (imem_rd_en !== exp_rd() || instr_valid !== m_valid)
        $display("FAIL rnd_ctl t=%0d rd=%0b v=%0b expected rd=%0b v=%0b",
                 t, imem_rd_en, instr_valid, exp_rd(), m_valid);
      else n_pass++;
      n_checks++;
      if (instr !== m_instr || instr_pc !== m_ipc)
        $display("FAIL rnd_word t=%0d got (%0h,%0h) expected (%0h,%0h)", t, instr, instr_pc, m_instr, m_ipc);
      else n_pass++;
`ifdef INSTR_FETCH_PERF_EN
      n_checks++;
      if (fetch_count !== 16'(m_count))
        $display("FAIL rnd_count t=%0d got %0d expected %0d", t, fetch_count, m_count);
      else n_pass++;
`endif
    end
    halt = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 6'd2;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    n_checks++;
    if (instr_valid !== 1'b1)
      $display("FAIL areset_hold got v=%0b expected v=1 before reset", instr_valid);
    else n_pass++;
`ifdef INSTR_FETCH_PERF_EN
    n_checks++;
    if (fetch_count !== 16'(m_count))
      $display("FAIL areset_count_before got %0d expected %0d", fetch_count, m_count);
    else n_pass++;
`endif
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pc, instr, instr_pc, instr_valid, imem_rd_en, imem_addr} !== '0)
      $display("FAIL areset_outputs pc=%0h instr=%0h ipc=%0h v=%0b rd=%0b addr=%0h expected all 0",
               pc, instr, instr_pc, instr_valid, imem_rd_en, imem_addr);
    else n_pass++;
`ifdef INSTR_FETCH_PERF_EN
    n_checks++;
    if (fetch_count !== 16'd0) $display("FAIL areset_count got %0d expected 0", fetch_count);
    else n_pass++;
`endif
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_redirect_wait();
    test_halt();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
